// File: rtl/serial_mem_responder.sv
// serial_mem_responder: memory-side end of the 8-bit CPU<->memory serial link.
// Collects a 16-bit address (and 16-bit store data) as MSB-first byte pairs.
// Performs one word access on the memory port.
// For fetch/load, sends the read word back as two bytes after a data_ready pulse.
// Optional build macro SERIAL_MEM_RANGE_CHECK_EN:
//   when defined, addresses >= MEM_WORDS are rejected with an error pulse.
//   When undefined, upper address bits are simply truncated to ADDR_W.
module serial_mem_responder #(
    parameter int ADDR_W    = 12,
    parameter int MEM_WORDS = 4096,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        bus_in,
    input  logic              bus_valid,
    input  logic [1:0]        req_kind,
    output logic [7:0]        bus_out,
    output logic              receive_ready,
    output logic              data_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              error
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_LO, S_DATA_HI, S_DATA_LO,
        S_MEM_WR, S_MEM_RD, S_RESP, S_SEND_HI, S_SEND_LO
    } state_t;

    localparam logic [1:0]        K_STORE = 2'd2;
    localparam logic [1:0]        K_RSVD  = 2'd3;
    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [16:0]       MEM_LIMIT = 17'(MEM_WORDS);

    state_t           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [1:0]       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [15:0]      full_addr;

    // Address as it will look once the low byte on the bus is accepted.
    assign full_addr = {addr_q[15:8], bus_in};

`ifdef SERIAL_MEM_RANGE_CHECK_EN
    logic oor_q, oor_d;
    logic addr_oor;
    assign addr_oor = ({1'b0, full_addr} >= MEM_LIMIT);
`else
    // Range limit has no effect in this build; upper address bits are truncated.
    logic unused_range;
    assign unused_range = ({1'b0, full_addr} >= MEM_LIMIT);
`endif

    // State and frame registers; reset drops the FSM straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            kind_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef SERIAL_MEM_RANGE_CHECK_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef SERIAL_MEM_RANGE_CHECK_EN
            oor_q   <= oor_d;
`endif
        end
    end

    // Next-state logic: byte capture, memory handshake, timeout and fault detection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        kind_d  = kind_q;
        cnt_d   = '0;
        err_d   = 1'b0;
`ifdef SERIAL_MEM_RANGE_CHECK_EN
        oor_d   = oor_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus_valid) begin
                    if (req_kind == K_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = {bus_in, 8'h00};
                        kind_d  = req_kind;
                        state_d = S_ADDR_LO;
                    end
                end
            end
            S_ADDR_LO: begin
                if (bus_valid) begin
                    addr_d  = full_addr;
                    state_d = (kind_q == K_STORE) ? S_DATA_HI : S_MEM_RD;
`ifdef SERIAL_MEM_RANGE_CHECK_EN
                    oor_d = addr_oor;
                    if (addr_oor) begin
                        err_d = 1'b1;
                        if (kind_q != K_STORE) begin
                            rdata_d = 16'hFFFF;
                            state_d = S_RESP;
                        end
                    end
`endif
                end
            end
            S_DATA_HI: begin
                if (bus_valid) begin
                    wdata_d = {bus_in, wdata_q[7:0]};
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (bus_valid) begin
                    wdata_d = {wdata_q[15:8], bus_in};
                    state_d = S_MEM_WR;
`ifdef SERIAL_MEM_RANGE_CHECK_EN
                    if (oor_q) state_d = S_IDLE;
`endif
                end
            end
            S_MEM_WR: begin
                if (mem_ack) state_d = S_IDLE;
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP:    state_d = S_SEND_HI;
            S_SEND_HI: state_d = S_SEND_LO;
            S_SEND_LO: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Inter-byte timeout while a frame is partially received.
        if ((state_q == S_ADDR_LO || state_q == S_DATA_HI || state_q == S_DATA_LO) && !bus_valid) begin
            if (cnt_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A byte offered while the responder is not listening is dropped and flagged.
        if (bus_valid && (state_q == S_MEM_WR || state_q == S_MEM_RD || state_q == S_RESP ||
                          state_q == S_SEND_HI || state_q == S_SEND_LO)) begin
            err_d = 1'b1;
        end
    end

    assign receive_ready = (state_q == S_IDLE);
    assign data_ready    = (state_q == S_RESP);
    assign mem_we        = (state_q == S_MEM_WR);
    assign mem_re        = (state_q == S_MEM_RD);
    assign mem_addr      = addr_q[ADDR_W-1:0];
    assign mem_wdata     = wdata_q;
    assign error         = err_q;
    assign bus_out       = (state_q == S_SEND_HI) ? rdata_q[15:8] :
                           (state_q == S_SEND_LO) ? rdata_q[7:0]  : 8'h00;

endmodule

// File: doc/serial_mem_responder.md
Name: serial_mem_responder

Overview:
- Memory-side end of the 8-bit CPU↔memory serial link that the CPU control FSM drives.
- Receives 16-bit PC/address words and store data as two bytes each, MSB first.
- Performs the access on a word-wide memory port, then returns instruction/load data as two bytes.
- Generates the `receive_ready` / `data_ready` handshakes the CPU control FSM waits on.

Parameters:
- ADDR_W, 12, memory word-address width; `mem_addr` = `addr[ADDR_W-1:0]`.
- MEM_WORDS, 4096, number of implemented words; used only by the optional range check.
- TIMEOUT, 16, maximum idle cycles allowed between bytes of one frame before abort.

Ports:
- clk in 1: system clock; all logic on posedge.
- rst_n in 1: reset, asynchronous assert, active-low.
- bus_in in 8: byte from CPU (PC/MAR/MDR mux).
- bus_valid in 1: CPU is driving a byte this cycle (OR of bus_pc/bus_mar/bus_mdr).
- req_kind in 2: 0 FETCH, 1 LOAD, 2 STORE, 3 reserved; sampled with the first byte.
- bus_out out 8: byte to CPU, meaningful only in SEND_HI/SEND_LO.
- receive_ready out 1: responder can accept a new frame.
- data_ready out 1: one-cycle pulse; response bytes follow on the next two cycles.
- mem_addr out ADDR_W: word address.
- mem_wdata out 16: store data.
- mem_we out 1: write strobe.
- mem_re out 1: read strobe.
- mem_rdata in 16: read data.
- mem_ack in 1: access complete; rdata valid when mem_re and mem_ack are both high.
- error out 1: one-cycle pulse on abort/protocol fault.

Behaviour:
- Reset: state IDLE; all outputs 0 except `receive_ready`=1; addr/data/kind registers cleared; timeout counter 0.
- IDLE: `receive_ready`=1. On `bus_valid`: latch `addr[15:8]`=`bus_in`, latch `req_kind` → ADDR_LO.
  - If `req_kind`==3: pulse error, stay IDLE.
- ADDR_LO: on `bus_valid`: `addr[7:0]`=`bus_in`. STORE → DATA_HI; FETCH/LOAD → MEM_RD.
- DATA_HI / DATA_LO: capture `wdata[15:8]` then `wdata[7:0]` on `bus_valid`. DATA_LO → MEM_WR.
- MEM_WR: `mem_we`=1 with addr/wdata held until `mem_ack`.
  - Then IDLE; `receive_ready` reasserts the following cycle. No response bytes for a store.
- MEM_RD: `mem_re`=1 until `mem_ack`. Latch `mem_rdata` → RESP.
- RESP: `data_ready`=1 for exactly one cycle → SEND_HI.
- SEND_HI: `bus_out`=`rdata[15:8]` → SEND_LO.
- SEND_LO: `bus_out`=`rdata[7:0]` → IDLE.
- Minimum latencies:
  - Fetch: `data_ready` 1 cycle after `mem_ack`; last byte on bus at `mem_ack`+3.
  - Store: write asserted the cycle after the 4th byte.
- The CPU must be in its wait state when `data_ready` pulses. The responder does not re-send.
- `receive_ready`=0 in every state except IDLE. `bus_valid` while not in an expecting state (MEM_*, RESP, SEND_*) is ignored and pulses error.
- Timeout: counter runs in ADDR_LO/DATA_HI/DATA_LO while `bus_valid`=0 and clears on each accepted byte. On reaching TIMEOUT: error pulse, → IDLE, partial frame discarded, no memory access.
- `mem_ack` arriving without `mem_re`/`mem_we` asserted is ignored.
- Reset mid-frame or mid-access: immediate return to reset state; in-flight strobes drop asynchronously.

Optional Feature:
- Macro SERIAL_MEM_RANGE_CHECK_EN.
- Defined: in ADDR_LO, if the full 16-bit addr ≥ MEM_WORDS, then:
  - LOAD/FETCH: skip MEM_RD; respond with 0xFFFF via RESP/SEND; pulse error.
  - STORE: still consume the two data bytes; skip MEM_WR; pulse error.
- Undefined: upper address bits are silently truncated to ADDR_W and the access always proceeds.

Test Plan:
- Fetch: bytes 0x01,0x23 kind FETCH, `mem_rdata`=0xBEEF, ack after 2 cycles → `mem_addr`=0x123, `data_ready` pulse, then `bus_out` 0xBE, 0xEF, `receive_ready` back to 1.
- Store: bytes 0x00,0x40,0xCA,0xFE kind STORE, immediate ack → `mem_we` with `mem_addr`=0x040, `mem_wdata`=0xCAFE; no `data_ready`.
- Load then fetch back-to-back, second frame starting the cycle `receive_ready` rises → both served, bytes in order, no error.
- Timeout: one byte 0x12, then idle 16 cycles → error pulse, IDLE, no `mem_re`/`mem_we`; next frame served normally.
- `rst_n` low during MEM_RD → `mem_re`=0 immediately, `receive_ready`=1 after release, no `data_ready`.
- With SERIAL_MEM_RANGE_CHECK_EN: LOAD addr 0x2000 → no `mem_re`, error pulse, response 0xFF,0xFF; without the macro → `mem_addr`=0x000 read.
